l2_way_bank: RTL and testbench

//  Parametrised N-way set-associative storage bank for the L2 cache: per-way valid/dirty/tag

---
 rtl/l2_way_bank.sv | 261 ++++++++++++++++++++++++++
 tb/tb_l2_way_bank.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_way_bank.sv
// N-way set-associative L2 storage bank: valid/dirty/tag/data per way, tag compare,
// victim choice and flush sweep. Define L2_WAY_PLRU_EN for per-set tree pseudo-LRU.
module l2_way_bank #(
  parameter int NUM_WAYS   = 4,
  parameter int S_INDEX    = 3,
  parameter int TAG_WIDTH  = 24,
  parameter int LINE_BYTES = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lookup_i,
  input  logic [S_INDEX-1:0]          index_i,
  input  logic [TAG_WIDTH-1:0]        tag_i,
  input  logic                        write_i,
  input  logic                        fill_i,
  input  logic [$clog2(NUM_WAYS)-1:0] way_i,
  input  logic [LINE_BYTES-1:0]       byte_enable_i,
  input  logic [8*LINE_BYTES-1:0]     data_i,
  input  logic                        fill_dirty_i,
  input  logic                        inval_all_i,
  output logic                        hit_o,
  output logic [$clog2(NUM_WAYS)-1:0] hit_way_o,
  output logic [8*LINE_BYTES-1:0]     data_o,
  output logic                        dirty_o,
  output logic [$clog2(NUM_WAYS)-1:0] victim_way_o,
  output logic                        victim_valid_o,
  output logic [TAG_WIDTH-1:0]        victim_tag_o,
  output logic                        busy_o
);

  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int SETS   = 2**S_INDEX;
  localparam int LINE_W = 8*LINE_BYTES;
  localparam logic [S_INDEX-1:0] LAST_SET = '1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t               state_reg, state_next;
  logic [S_INDEX-1:0]   cnt_reg, cnt_next;
  logic                 busy;
  logic                 lookup_acc, write_acc, fill_acc;

  logic [NUM_WAYS-1:0]  valid_reg [SETS];
  logic [NUM_WAYS-1:0]  dirty_reg [SETS];

  logic [TAG_WIDTH-1:0] way_tag   [NUM_WAYS];
  logic [LINE_W-1:0]    way_rdata [NUM_WAYS];

  logic [NUM_WAYS-1:0]  set_valid, match;
  logic                 hit_c, has_inv_c;
  logic [WAY_W-1:0]     hit_way_c, inv_way_c, policy_way_c, victim_c, sel_c;

  logic                 hit_reg, dirty_out_reg, victim_valid_reg;
  logic [WAY_W-1:0]     hit_way_reg, victim_way_reg, sel_way_reg;
  logic [TAG_WIDTH-1:0] victim_tag_reg;

  assign busy       = (state_reg == SWEEP);
  assign lookup_acc = lookup_i & ~busy;
  assign fill_acc   = fill_i & ~busy;
  assign write_acc  = write_i & ~fill_i & ~busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (inval_all_i) begin
          state_next = SWEEP;
          cnt_next   = '0;
        end
      end
      SWEEP: begin
        if (cnt_reg == LAST_SET) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Valid/dirty live in flops so reset and the sweep can clear them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        dirty_reg[s] <= '0;
      end
    end else if (busy) begin
      valid_reg[cnt_reg] <= '0;
      dirty_reg[cnt_reg] <= '0;
    end else if (fill_acc) begin
      valid_reg[index_i][way_i] <= 1'b1;
      dirty_reg[index_i][way_i] <= fill_dirty_i;
    end else if (write_acc) begin
      dirty_reg[index_i][way_i] <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
    localparam logic [WAY_W-1:0] WAY_ID = WAY_W'(gi);
    logic [TAG_WIDTH-1:0] tag_mem  [SETS];
    logic [LINE_W-1:0]    data_mem [SETS];
    logic [LINE_W-1:0]    rd_data_reg;
    logic [LINE_BYTES-1:0] be;
    logic                 we;

    assign we = (fill_acc | write_acc) && (way_i == WAY_ID);
    assign be = fill_acc ? '1 : byte_enable_i;

    always_ff @(posedge clk) begin
      if (fill_acc && way_i == WAY_ID)
        tag_mem[index_i] <= tag_i;
      for (int b = 0; b < LINE_BYTES; b++)
        if (we && be[b])
          data_mem[index_i][8*b +: 8] <= data_i[8*b +: 8];
    end

    // Read register captures pre-write contents when a write hits the same set.
    always_ff @(posedge clk) begin
      if (rst)
        rd_data_reg <= '0;
      else if (lookup_acc)
        rd_data_reg <= data_mem[index_i];
    end

    assign way_tag[gi]   = tag_mem[index_i];
    assign way_rdata[gi] = rd_data_reg;
  end

  always_comb begin
    set_valid = valid_reg[index_i];
    match     = '0;
    hit_c     = 1'b0;
    hit_way_c = '0;
    has_inv_c = 1'b0;
    inv_way_c = '0;
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      match[w] = set_valid[w] && (way_tag[w] == tag_i);
      if (match[w]) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
      if (!set_valid[w]) begin
        has_inv_c = 1'b1;
        inv_way_c = WAY_W'(w);
      end
    end
  end

`ifdef L2_WAY_PLRU_EN
  logic [NUM_WAYS-2:0] plru_reg [SETS];
  logic [NUM_WAYS-2:0] plru_touched, plru_upd;
  logic                plru_we;

  // Node n (1-based heap order) is stored at bit n-1; a 1 steers the victim right.
  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] bits,
                                                     input logic [WAY_W-1:0] way);
    logic [NUM_WAYS-2:0] b;
    logic [WAY_W-1:0]    node;
    b    = bits;
    node = WAY_W'(1);
    for (int l = WAY_W-1; l >= 0; l--) begin
      b[node - 1'b1] = ~way[l];
      node = (node << 1) | WAY_W'(way[l]);
    end
    return b;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] bits);
    logic [WAY_W-1:0] v;
    logic [WAY_W-1:0] node;
    v    = '0;
    node = WAY_W'(1);
    for (int l = WAY_W-1; l >= 0; l--) begin
      v[l] = bits[node - 1'b1];
      node = (node << 1) | WAY_W'(bits[node - 1'b1]);
    end
    return v;
  endfunction

  // The victim reported with a hit already reflects that hit's own recency update.
  always_comb begin
    plru_touched = hit_c ? plru_touch(plru_reg[index_i], hit_way_c) : plru_reg[index_i];
    policy_way_c = plru_victim(plru_touched);
    plru_upd     = (lookup_acc && hit_c) ? plru_touched : plru_reg[index_i];
    if (fill_acc || write_acc)
      plru_upd = plru_touch(plru_upd, way_i);
    plru_we = (lookup_acc && hit_c) || fill_acc || write_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        plru_reg[s] <= '0;
    end else if (busy) begin
      plru_reg[cnt_reg] <= '0;
    end else if (plru_we) begin
      plru_reg[index_i] <= plru_upd;
    end
  end
`else
  logic [WAY_W-1:0] rr_reg;

  always_ff @(posedge clk) begin
    if (rst)
      rr_reg <= '0;
    else if (fill_acc)
      rr_reg <= rr_reg + 1'b1;
  end

  assign policy_way_c = rr_reg;
`endif

  always_comb begin
    victim_c = has_inv_c ? inv_way_c : policy_way_c;
    sel_c    = hit_c ? hit_way_c : victim_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_reg          <= 1'b0;
      hit_way_reg      <= '0;
      sel_way_reg      <= '0;
      dirty_out_reg    <= 1'b0;
      victim_way_reg   <= '0;
      victim_valid_reg <= 1'b0;
      victim_tag_reg   <= '0;
    end else if (lookup_acc) begin
      hit_reg          <= hit_c;
      hit_way_reg      <= hit_way_c;
      sel_way_reg      <= sel_c;
      dirty_out_reg    <= dirty_reg[index_i][sel_c];
      victim_way_reg   <= victim_c;
      victim_valid_reg <= set_valid[victim_c];
      victim_tag_reg   <= way_tag[victim_c];
    end
  end

  assign hit_o          = hit_reg & ~busy;
  assign hit_way_o      = hit_way_reg;
  assign data_o         = way_rdata[sel_way_reg];
  assign dirty_o        = dirty_out_reg;
  assign victim_way_o   = victim_way_reg;
  assign victim_valid_o = victim_valid_reg;
  assign victim_tag_o   = victim_tag_reg;
  assign busy_o         = busy;

endmodule

// File: tb/tb_l2_way_bank.sv
// Scoreboard bench for l2_way_bank: a small line model predicts each lookup's result,
// queued when the lookup is driven and compared one cycle later.
module tb_l2_way_bank;

  logic         clk = 1'b0;
  logic         rst, lookup_i, write_i, fill_i, fill_dirty_i, inval_all_i;
  logic [2:0]   index_i;
  logic [23:0]  tag_i;
  logic [1:0]   way_i;
  logic [31:0]  byte_enable_i;
  logic [255:0] data_i;
  logic         hit_o, dirty_o, victim_valid_o, busy_o;
  logic [1:0]   hit_way_o, victim_way_o;
  logic [255:0] data_o;
  logic [23:0]  victim_tag_o;

`ifdef L2_WAY_PLRU_EN
  localparam int VIC_FULL = 2;
`else
  localparam int VIC_FULL = 0;
`endif

  l2_way_bank dut (
    .clk(clk), .rst(rst), .lookup_i(lookup_i), .index_i(index_i), .tag_i(tag_i),
    .write_i(write_i), .fill_i(fill_i), .way_i(way_i), .byte_enable_i(byte_enable_i),
    .data_i(data_i), .fill_dirty_i(fill_dirty_i), .inval_all_i(inval_all_i),
    .hit_o(hit_o), .hit_way_o(hit_way_o), .data_o(data_o), .dirty_o(dirty_o),
    .victim_way_o(victim_way_o), .victim_valid_o(victim_valid_o),
    .victim_tag_o(victim_tag_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         hit;
    logic [1:0]   hit_way;
    logic         vic_known;
    logic [1:0]   vic_way;
    logic         vic_valid;
    logic [23:0]  vic_tag;
    logic         sel_known;
    logic         data_known;
    logic [255:0] data;
    logic         dirty;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  bit           m_valid [8][4];
  bit           m_dirty [8][4];
  bit           m_datak [8][4];
  logic [23:0]  m_tag   [8][4];
  logic [255:0] m_data  [8][4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
  endtask

  task automatic idle_inputs();
    lookup_i = 0; write_i = 0; fill_i = 0; inval_all_i = 0; fill_dirty_i = 0;
    index_i = '0; tag_i = '0; way_i = '0; byte_enable_i = '0; data_i = '0;
  endtask

  // One clock of stimulus: optional lookup plus optional write/fill, all on index idx.
  task automatic cycle(input bit lk, input bit wr, input bit fl, input logic [2:0] idx,
                       input logic [23:0] tag, input logic [1:0] way, input logic [31:0] be,
                       input logic [255:0] d, input bit fdirty, input int exp_vic,
                       input string name);
    exp_t e;
    int   sel;
    if (lk) begin
      e = '{default: '0};
      for (int w = 3; w >= 0; w--)
        if (m_valid[idx][w] && m_tag[idx][w] == tag) begin
          e.hit = 1'b1; e.hit_way = 2'(w);
        end
      for (int w = 3; w >= 0; w--)
        if (!m_valid[idx][w]) begin
          e.vic_known = 1'b1; e.vic_way = 2'(w);
        end
      if (!e.vic_known && exp_vic >= 0) begin
        e.vic_known = 1'b1; e.vic_way = 2'(exp_vic);
      end
      if (e.vic_known) begin
        e.vic_valid = m_valid[idx][e.vic_way];
        e.vic_tag   = m_tag[idx][e.vic_way];
      end
      e.sel_known = e.hit || e.vic_known;
      sel = e.hit ? int'(e.hit_way) : int'(e.vic_way);
      if (e.sel_known) begin
        e.dirty      = m_dirty[idx][sel];
        e.data_known = m_datak[idx][sel];
        e.data       = m_data[idx][sel];
      end
      sb_q.push_back(e);
    end
    if (fl) begin
      m_valid[idx][way] = 1'b1; m_dirty[idx][way] = fdirty; m_tag[idx][way] = tag;
      m_data[idx][way] = d;     m_datak[idx][way] = 1'b1;
    end else if (wr) begin
      for (int b = 0; b < 32; b++)
        if (be[b]) m_data[idx][way][8*b +: 8] = d[8*b +: 8];
      m_dirty[idx][way] = 1'b1;
    end
    lookup_i = lk; write_i = wr; fill_i = fl; index_i = idx; tag_i = tag; way_i = way;
    byte_enable_i = be; data_i = d; fill_dirty_i = fdirty;
    tick();
    idle_inputs();
    if (lk) begin
      e = sb_q.pop_front();
      n_vec++;
      if (hit_o !== e.hit) begin
        n_err++; $display("FAIL %s hit_o: got %0b expected %0b", name, hit_o, e.hit);
      end
      if (e.hit) begin
        n_vec++;
        if (hit_way_o !== e.hit_way) begin
          n_err++; $display("FAIL %s hit_way_o: got %0d expected %0d", name, hit_way_o, e.hit_way);
        end
      end
      if (e.vic_known) begin
        n_vec += 2;
        if (victim_way_o !== e.vic_way) begin
          n_err++; $display("FAIL %s victim_way_o: got %0d expected %0d", name, victim_way_o, e.vic_way);
        end
        if (victim_valid_o !== e.vic_valid) begin
          n_err++; $display("FAIL %s victim_valid_o: got %0b expected %0b", name, victim_valid_o, e.vic_valid);
        end
        if (e.vic_valid) begin
          n_vec++;
          if (victim_tag_o !== e.vic_tag) begin
            n_err++; $display("FAIL %s victim_tag_o: got %h expected %h", name, victim_tag_o, e.vic_tag);
          end
        end
      end
      if (e.sel_known) begin
        n_vec++;
        if (dirty_o !== e.dirty) begin
          n_err++; $display("FAIL %s dirty_o: got %0b expected %0b", name, dirty_o, e.dirty);
        end
      end
      if (e.data_known) begin
        n_vec++;
        if (data_o !== e.data) begin
          n_err++; $display("FAIL %s data_o: got %h expected %h", name, data_o, e.data);
        end
      end
      $display("lookup %s: set %0d tag %h -> hit %0b way %0d victim %0d", name, idx, tag,
               hit_o, hit_way_o, victim_way_o);
    end
  endtask

  task automatic lookup(input logic [2:0] idx, input logic [23:0] tag, input int exp_vic,
                        input string name);
    cycle(1, 0, 0, idx, tag, 2'd0, '0, '0, 0, exp_vic, name);
  endtask

  task automatic fill(input logic [2:0] idx, input logic [1:0] way, input logic [23:0] tag,
                      input logic [255:0] d, input bit fdirty);
    cycle(0, 0, 1, idx, tag, way, '0, d, fdirty, -1, "fill");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    n_vec += 5;
    if (hit_o !== 1'b0)          begin n_err++; $display("FAIL reset hit_o: got %0b expected 0", hit_o); end
    if (busy_o !== 1'b0)         begin n_err++; $display("FAIL reset busy_o: got %0b expected 0", busy_o); end
    if (data_o !== '0)           begin n_err++; $display("FAIL reset data_o: got %h expected 0", data_o); end
    if (victim_valid_o !== 1'b0) begin n_err++; $display("FAIL reset victim_valid_o: got %0b expected 0", victim_valid_o); end
    if (victim_tag_o !== '0)     begin n_err++; $display("FAIL reset victim_tag_o: got %h expected 0", victim_tag_o); end
    lookup(3'd0, 24'h0, -1, "reset_set0");
    n_vec++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy_after_lookup: got %0b expected 0", busy_o); end
  endtask

  task automatic test_fill_lookup();
    fill(3'd3, 2'd2, 24'hABCDEF, rand_line(), 1'b0);
    lookup(3'd3, 24'hABCDEF, -1, "fill_hit");
    lookup(3'd3, 24'h123456, -1, "fill_miss");
  endtask

  task automatic test_write();
    logic [255:0] held;
    cycle(0, 1, 0, 3'd3, 24'h0, 2'd2, 32'h1, {256{1'b1}}, 0, -1, "write");
    lookup(3'd3, 24'hABCDEF, -1, "write_byte0");
    held = data_o;
    cycle(0, 1, 0, 3'd3, 24'h0, 2'd2, $urandom, rand_line(), 0, -1, "write_rand");
    tick();
    n_vec++;
    if (data_o !== held) begin
      n_err++; $display("FAIL write_hold data_o: got %h expected %h", data_o, held);
    end
    lookup(3'd3, 24'hABCDEF, -1, "write_rand_be");
  endtask

  task automatic test_same_cycle();
    fill(3'd5, 2'd1, 24'h000055, rand_line(), 1'b0);
    cycle(1, 0, 1, 3'd5, 24'h000055, 2'd1, '0, rand_line(), 1'b1, -1, "rbw_old");
    lookup(3'd5, 24'h000055, -1, "rbw_gone");
    cycle(0, 1, 1, 3'd5, 24'h000066, 2'd1, 32'hFFFF_FFFF, rand_line(), 1'b0, -1, "fill_write");
    lookup(3'd5, 24'h000066, -1, "fill_wins");
  endtask

  task automatic test_victim();
    do_reset();
    for (int w = 0; w < 4; w++)
      fill(3'd1, 2'(w), 24'h000100 + 24'(w), rand_line(), w[0]);
    lookup(3'd1, 24'h000100, VIC_FULL, "victim_hit0");
    lookup(3'd1, 24'h000999, VIC_FULL, "victim_miss");
  endtask

  task automatic test_sweep();
    fill(3'd3, 2'd0, 24'h000333, rand_line(), 1'b1);
    lookup(3'd3, 24'h000333, -1, "pre_sweep");
    inval_all_i = 1'b1;
    tick();
    inval_all_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      n_vec += 2;
      if (busy_o !== 1'b1) begin n_err++; $display("FAIL sweep_busy cycle %0d: got %0b expected 1", c, busy_o); end
      if (hit_o !== 1'b0)  begin n_err++; $display("FAIL sweep_hit cycle %0d: got %0b expected 0", c, hit_o); end
      lookup_i = 1; index_i = 3'd3; tag_i = 24'h000333;
      fill_i = 1; way_i = 2'd0; data_i = rand_line();
      inval_all_i = (c == 6);
      tick();
      idle_inputs();
    end
    model_clear();
    n_vec++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL sweep_end busy_o: got %0b expected 0", busy_o); end
    $display("sweep: busy_o low after 8 cycles = %0b", ~busy_o);
    lookup(3'd3, 24'h000333, -1, "post_sweep");
    lookup(3'd1, 24'h000100, -1, "post_sweep_set1");
  endtask

  task automatic test_reset_mid_sweep();
    inval_all_i = 1'b1;
    tick();
    inval_all_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    n_vec++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL mid_sweep_reset busy_o: got %0b expected 0", busy_o); end
    tick();
    n_vec++;
    if (busy_o !== 1'b0) begin n_err++; $display("FAIL mid_sweep_idle busy_o: got %0b expected 0", busy_o); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] tags [8];
    for (int s = 0; s < 8; s++) begin
      tags[s] = 24'($urandom);
      fill(3'(s), 2'(s % 4), tags[s], rand_line(), s[1]);
    end
    for (int s = 0; s < 8; s++)
      lookup(3'(s), (s % 3 == 0) ? ~tags[s] : tags[s], -1, "b2b");
  endtask

  initial begin
    test_reset();
    test_fill_lookup();
    test_write();
    test_same_cycle();
    test_victim();
    test_sweep();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
